// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store ports onto one fixed-latency memory, one transaction in flight.
// Optional ARB_RR_EN: round-robin tie-breaking; otherwise data always wins ties.
module mem_arbiter #(
    parameter int Nbits = 32,
    parameter int LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [63:0]      if_addr,
    output logic             if_gnt,
    output logic             if_rvalid,
    output logic [Nbits-1:0] if_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [63:0]      d_addr,
    input  logic [Nbits-1:0] d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [Nbits-1:0] d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [63:0]      mem_addr,
    output logic [Nbits-1:0] mem_wdata,
    input  logic [Nbits-1:0] mem_rdata
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam logic [2:0] LAT3   = 3'(LAT);

    logic [1:0] state;
    logic [2:0] cnt;
    logic       wr_pend;
    logic       arb_open;
    logic       done;
    logic       tie_d;
    logic       d_win;
`ifdef ARB_RR_EN
    logic       last_owner;  // 1 = data, 0 = fetch
`endif

    always_comb begin
        // rst gating keeps every output quiet in a cycle where reset is being sampled
        arb_open = rst && ((state == IDLE) || (cnt == 3'd1));
        done     = rst && (state != IDLE) && (cnt == 3'd1);
`ifdef ARB_RR_EN
        tie_d    = !last_owner;
`else
        tie_d    = 1'b1;
`endif
        d_win     = d_req && (!if_req || tie_d);
        d_gnt     = arb_open && d_win;
        if_gnt    = arb_open && if_req && !d_win;
        if_rvalid = done && (state == BUSY_I);
        d_rvalid  = done && (state == BUSY_D);
        if_rdata  = if_rvalid ? mem_rdata : '0;
        d_rdata   = (d_rvalid && !wr_pend) ? mem_rdata : '0;
        mem_en    = if_gnt || d_gnt;
        mem_we    = d_gnt && d_we;
        mem_addr  = d_gnt ? d_addr : (if_gnt ? if_addr : 64'd0);
        mem_wdata = d_gnt ? d_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            wr_pend <= 1'b0;
        end else if (if_gnt) begin
            state <= BUSY_I;
            cnt   <= LAT3;
        end else if (d_gnt) begin
            state   <= BUSY_D;
            cnt     <= LAT3;
            wr_pend <= d_we;
        end else if (arb_open) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            cnt <= cnt - 3'd1;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk) begin
        if (!rst)
            last_owner <= 1'b1;
        else if (mem_en)
            last_owner <= d_gnt;
    end
`endif
endmodule
